fb_delta_encoder: RTL and testbench

Raster-order pixel encoder that writes the column-delta framebuffer format read by the VGA output path. The encoder takes one full 320x240 frame of 3-bit palette indices and writes a framebuffer word for every pixel. Each word is either the new color where a column's color changes, or 0 meaning "same as last nonzero color above in this column". It sits between the drawing/compositing logic and the framebuffer write port. Writing every pixel means the framebuffer never needs a separate clear pass.

---
 rtl/fb_delta_encoder_pkg.sv | 54 +++++
 rtl/fb_delta_encoder_column_mem.sv | 48 ++++
 rtl/fb_delta_encoder.sv | 229 ++++++++++++++++++++++
 tb/tb_fb_delta_encoder.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_delta_encoder_pkg.sv
// -----------------------------------------------------------------------------
// fb_delta_encoder_pkg
// Shared types for the column-delta framebuffer path: screen coordinates,
// palette indices, default frame geometry, encoder state encoding and the
// per-pixel delta encoding rule.
// -----------------------------------------------------------------------------
package fb_delta_encoder_pkg;

  // Default frame geometry, shared with the VGA output path.
  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;

  typedef logic [2:0] palette_index_t;

  // Framebuffer write address.
  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
  } screenXY;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } enc_state_t;

  // Result of encoding one pixel against the color its column shows.
  typedef struct packed {
    palette_index_t data;    // word to write (0 = keep color from above)
    logic           update;  // column memory takes the new color
    logic           lossy;   // pixel could not be represented
  } enc_result_t;

  // A column can only switch to a nonzero color; going back to 0 is
  // unrepresentable because 0 in the framebuffer means "unchanged".
  function automatic enc_result_t encode_pixel(input palette_index_t p,
                                               input palette_index_t last);
    enc_result_t r;
    r.data   = 3'd0;
    r.update = 1'b0;
    r.lossy  = 1'b0;
    if (p == last) begin
      r.data = 3'd0;
    end else if (p == 3'd0) begin
      r.lossy = 1'b1;
    end else begin
      r.data   = p;
      r.update = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fb_delta_encoder_column_mem.sv
// -----------------------------------------------------------------------------
// column_mem
// DEPTH x 3-bit synchronous RAM holding the color each column currently
// displays. One write per cycle; registered read data that only updates when
// re is high, so the value stays stable while the write stage is stalled.
// Ports:
//   Clk, Reset      clock, async active-high reset (read register only)
//   we/waddr/wdata  write port
//   re/raddr/rdata  registered read port
// -----------------------------------------------------------------------------
module column_mem
  import fb_delta_encoder_pkg::*;
#(
  parameter int DEPTH = FB_WIDTH,
  parameter int AW    = $clog2(FB_WIDTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [2:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [2:0]    rdata
);

  palette_index_t mem_r [DEPTH];
  palette_index_t rdata_r;

  // Storage write; contents are not reset because CLEAR rewrites them.
  always_ff @(posedge Clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read, held when no read is requested.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rdata_r <= 3'd0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/fb_delta_encoder.sv
// -----------------------------------------------------------------------------
// fb_delta_encoder
// Raster-order encoder producing the column-delta framebuffer format. Every
// pixel of a WIDTH x HEIGHT frame is written: the new color where a column's
// color changes, otherwise 0.
// Ports:
//   Clk, Reset          clock, async active-high reset
//   frame_start         start request, honored only in IDLE
//   pix_in/pix_valid    incoming raster pixel, handshake with pix_ready
//   fb_we/fb_coords/    framebuffer write request, address, data;
//   fb_data/fb_ready    completes when fb_we && fb_ready
//   busy                high while a frame is in progress
//   frame_done          one-cycle pulse after the final write
//   lossy_count         unrepresentable pixels in the current/last frame
// -----------------------------------------------------------------------------
module fb_delta_encoder
  import fb_delta_encoder_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic [2:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        fb_we,
  output screenXY     fb_coords,
  output logic [2:0]  fb_data,
  input  logic        fb_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [16:0] lossy_count
);

  localparam int         AW     = $clog2(WIDTH);
  localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  enc_state_t     state_r;
  enc_state_t     state_s;
  logic [8:0]     clr_addr_r;
  logic [8:0]     x_r;
  logic [7:0]     y_r;
  logic           stage_valid_r;
  screenXY        stage_xy_r;
  palette_index_t stage_pix_r;
  logic [16:0]    lossy_r;
  logic           frame_done_r;
  logic           busy_r;

  logic           pix_ready_s;
  logic           accept_s;
  logic           wr_done_s;
  logic           last_pixel_s;
  logic           drain_done_s;
  palette_index_t last_s;
  enc_result_t    enc_s;
  logic           mem_we_s;
  logic [AW-1:0]  mem_waddr_s;
  palette_index_t mem_wdata_s;

  assign pix_ready_s  = (state_r == ST_STREAM) && (!stage_valid_r || fb_ready);
  assign accept_s     = pix_valid && pix_ready_s;
  assign wr_done_s    = stage_valid_r && fb_ready;
  assign last_pixel_s = (x_r == X_LAST) && (y_r == Y_LAST);
  // Final write of the frame completing this cycle.
  assign drain_done_s = (state_r == ST_DRAIN) && wr_done_s;

  // The stored pixel is compared with the column color read at accept time.
  assign enc_s = encode_pixel(stage_pix_r, last_s);

  column_mem #(
    .DEPTH (WIDTH),
    .AW    (AW)
  ) u_column_mem (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (mem_we_s),
    .waddr (mem_waddr_s),
    .wdata (mem_wdata_s),
    .re    (accept_s),
    .raddr (x_r[AW-1:0]),
    .rdata (last_s)
  );

  // Column memory write select: clear sweep, or color change at write time.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = 3'd0;
    if (state_r == ST_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_addr_r[AW-1:0];
      mem_wdata_s = 3'd0;
    end else if (wr_done_s && enc_s.update) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = stage_xy_r.x[AW-1:0];
      mem_wdata_s = stage_pix_r;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_start) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_addr_r == X_LAST) begin
          state_s = ST_STREAM;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_STREAM: begin
        if (accept_s && last_pixel_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        // Leave only once the stage is empty: the frame_done cycle is still
        // spent here so a coincident frame_start is not honored.
        if (!stage_valid_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Clear sweep address, walks 0..WIDTH-1 during CLEAR.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clr_addr_r <= 9'd0;
    end else if (state_r == ST_CLEAR) begin
      clr_addr_r <= clr_addr_r + 9'd1;
    end else begin
      clr_addr_r <= 9'd0;
    end
  end

  // Raster position of the next pixel to accept.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_r <= 9'd0;
      y_r <= 8'd0;
    end else if (state_r != ST_STREAM) begin
      x_r <= 9'd0;
      y_r <= 8'd0;
    end else if (accept_s) begin
      if (x_r == X_LAST) begin
        x_r <= 9'd0;
        y_r <= y_r + 8'd1;
      end else begin
        x_r <= x_r + 9'd1;
      end
    end
  end

  // Write stage: holds one accepted pixel until the framebuffer takes it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stage_valid_r <= 1'b0;
      stage_xy_r    <= '0;
      stage_pix_r   <= 3'd0;
    end else if (accept_s) begin
      stage_valid_r <= 1'b1;
      stage_xy_r    <= '{x: x_r, y: y_r};
      stage_pix_r   <= pix_in;
    end else if (fb_ready) begin
      stage_valid_r <= 1'b0;
    end
  end

  // Lossy pixel counter; counted once at write completion, saturating.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lossy_r <= 17'd0;
    end else if ((state_r == ST_IDLE) && frame_start) begin
      lossy_r <= 17'd0;
    end else if (wr_done_s && enc_s.lossy && (lossy_r != {17{1'b1}})) begin
      lossy_r <= lossy_r + 17'd1;
    end
  end

  // Status outputs; busy drops together with the frame_done pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      frame_done_r <= drain_done_s;
      busy_r       <= (state_s != ST_IDLE) && !drain_done_s;
    end
  end

  assign pix_ready   = pix_ready_s;
  assign fb_we       = stage_valid_r;
  assign fb_coords   = stage_xy_r;
  assign fb_data     = stage_valid_r ? enc_s.data : 3'd0;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign lossy_count = lossy_r;

endmodule

// File: tb/tb_fb_delta_encoder.sv
// -----------------------------------------------------------------------------
// tb_fb_delta_encoder
// Directed bench for fb_delta_encoder. The frame height is shortened to keep
// run time small; width stays at the full 320 columns.
// -----------------------------------------------------------------------------
module tb_fb_delta_encoder;
  import fb_delta_encoder_pkg::*;

  localparam int W         = 320;
  localparam int H         = 8;
  localparam int FRAME_CYC = W * H + W + 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic [2:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic        fb_we;
  screenXY     fb_coords;
  logic [2:0]  fb_data;
  logic        fb_ready;
  logic        busy;
  logic        frame_done;
  logic [16:0] lossy_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2:0] img     [H][W];
  logic [2:0] exp_img [H][W];
  logic [2:0] wr_val  [H][W];
  int         wr_cnt  [H][W];
  int stray_wr, done_pulses, done_cyc, first_acc_cyc;
  int mon_stall_x = -1, mon_stall_y = -1;
  int after_x = -1, after_y = -1;
  logic prev_hit = 1'b0;
  int mx, my;

  fb_delta_encoder #(.WIDTH(W), .HEIGHT(H)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .fb_we(fb_we),
    .fb_coords(fb_coords), .fb_data(fb_data), .fb_ready(fb_ready),
    .busy(busy), .frame_done(frame_done), .lossy_count(lossy_count)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Write / frame_done monitor, sampled on the falling edge.
  always @(negedge Clk) begin
    if (Reset === 1'b0 && fb_we === 1'b1 && fb_ready === 1'b1) begin
      mx = int'(fb_coords.x);
      my = int'(fb_coords.y);
      if (mx < W && my < H) begin
        wr_val[my][mx] = fb_data;
        wr_cnt[my][mx] = wr_cnt[my][mx] + 1;
      end else begin
        stray_wr = stray_wr + 1;
      end
      if (prev_hit) begin
        after_x = mx; after_y = my; prev_hit = 1'b0;
      end
      if (mx == mon_stall_x && my == mon_stall_y) prev_hit = 1'b1;
    end
    if (frame_done === 1'b1) begin
      done_pulses = done_pulses + 1;
      done_cyc = cyc;
    end
  end

  task automatic clear_log();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        wr_val[y][x] = 3'd0; wr_cnt[y][x] = 0;
        img[y][x] = 3'd0; exp_img[y][x] = 3'd0;
      end
    stray_wr = 0; done_pulses = 0; done_cyc = -1; first_acc_cyc = -1;
    mon_stall_x = -1; mon_stall_y = -1; after_x = -1; after_y = -1;
  endtask

  task automatic start_frame(output int t0);
    frame_start = 1'b1;
    t0 = cyc;
    @(posedge Clk); #1;
    frame_start = 1'b0;
  endtask

  // Feeds rows 0..stop_y-1 from img; optional 5-cycle fb_ready stall after
  // pixel (sx,sy) is accepted; optional frame_start pulse with pixel fs_pix.
  task automatic feed_frame(input int sx, input int sy, input int fs_pix, input int stop_y);
    int tries, idx;
    logic ok;
    idx = 0;
    for (int y = 0; y < stop_y; y++) begin
      for (int x = 0; x < W; x++) begin
        pix_in = img[y][x];
        pix_valid = 1'b1;
        frame_start = (idx == fs_pix);
        ok = 1'b0; tries = 0;
        while (!ok && tries < 400) begin
          @(negedge Clk);
          if (pix_ready === 1'b1) begin
            ok = 1'b1;
            if (idx == 0) first_acc_cyc = cyc;
          end
          @(posedge Clk); #1;
          tries++;
        end
        frame_start = 1'b0;
        if (!ok) begin
          total++; bad++;
          $display("FAIL feed_stuck: pixel (%0d,%0d) pix_ready=%b required 1", x, y, pix_ready);
          pix_valid = 1'b0;
          return;
        end
        if (x == sx && y == sy && x + 1 < W) begin
          fb_ready = 1'b0;
          pix_in = img[y][x+1];
          for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            total++;
            if (fb_we !== 1'b1 || fb_coords !== screenXY'{x: 9'(sx), y: 8'(sy)} ||
                fb_data !== exp_img[sy][sx] || pix_ready !== 1'b0) begin
              bad++;
              $display("FAIL stall_hold[%0d]: we=%b xy=(%0d,%0d) data=%0d rdy=%b required we=1 xy=(%0d,%0d) data=%0d rdy=0",
                       k, fb_we, fb_coords.x, fb_coords.y, fb_data, pix_ready, sx, sy, exp_img[sy][sx]);
            end
            @(posedge Clk); #1;
          end
          fb_ready = 1'b1;
        end
        idx++;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [16:0] exp_lossy);
    int errs, fx, fy;
    for (int k = 0; k < 50 && done_pulses == 0; k++) begin @(posedge Clk); #1; end
    repeat (4) begin @(posedge Clk); #1; end
    total++;
    if (done_pulses != 1) begin
      bad++; $display("FAIL %s_done_pulses: got %0d required 1", name, done_pulses);
    end
    errs = 0; fx = 0; fy = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (wr_cnt[y][x] != 1 || wr_val[y][x] !== exp_img[y][x]) begin
          if (errs == 0) begin fx = x; fy = y; end
          errs++;
        end
    total++;
    if (errs != 0 || stray_wr != 0) begin
      bad++;
      $display("FAIL %s_image: %0d bad pixels, %0d stray; first (%0d,%0d) writes=%0d data=%0d required writes=1 data=%0d",
               name, errs, stray_wr, fx, fy, wr_cnt[fy][fx], wr_val[fy][fx], exp_img[fy][fx]);
    end
    total++;
    if (lossy_count !== exp_lossy) begin
      bad++; $display("FAIL %s_lossy: got %0d required %0d", name, lossy_count, exp_lossy);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s_busy_after: got %b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; frame_start = 1'b0; pix_in = 3'd0; pix_valid = 1'b0; fb_ready = 1'b1;
    repeat (3) begin @(posedge Clk); #1; end
    @(negedge Clk);
    total++;
    if (pix_ready !== 1'b0 || fb_we !== 1'b0 || fb_coords !== 17'd0 || fb_data !== 3'd0 ||
        busy !== 1'b0 || frame_done !== 1'b0 || lossy_count !== 17'd0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b we=%b xy=%h data=%0d busy=%b done=%b lossy=%0d required all 0",
               pix_ready, fb_we, fb_coords, fb_data, busy, frame_done, lossy_count);
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  // Solid color 5 at full throughput, including frame timing.
  task automatic test_solid();
    int t0;
    clear_log();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        img[y][x] = 3'd5;
        exp_img[y][x] = (y == 0) ? 3'd5 : 3'd0;
      end
    total++;
    if (busy !== 1'b0 || pix_ready !== 1'b0) begin
      bad++; $display("FAIL idle_state: busy=%b rdy=%b required 0 0", busy, pix_ready);
    end
    start_frame(t0);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL busy_rise: got %b required 1", busy);
    end
    feed_frame(-1, -1, -1, H);
    check_frame("solid", 17'd0);
    total++;
    if (first_acc_cyc != t0 + W + 1) begin
      bad++; $display("FAIL first_ready: cycle %0d required %0d", first_acc_cyc - t0, W + 1);
    end
    total++;
    if (done_cyc != t0 + FRAME_CYC) begin
      bad++; $display("FAIL done_time: cycle %0d required %0d", done_cyc - t0, FRAME_CYC);
    end
  endtask

  // Column 7: 0,0,3,3,6,... and column 2: 4,0,4,...
  task automatic test_columns();
    int t0;
    logic [2:0] c7_in  [8];
    logic [2:0] c7_exp [8];
    logic [2:0] c2_in  [8];
    logic [2:0] c2_exp [8];
    c7_in  = '{3'd0, 3'd0, 3'd3, 3'd3, 3'd6, 3'd6, 3'd6, 3'd6};
    c7_exp = '{3'd0, 3'd0, 3'd3, 3'd0, 3'd6, 3'd0, 3'd0, 3'd0};
    c2_in  = '{3'd4, 3'd0, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    c2_exp = '{3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    clear_log();
    for (int y = 0; y < H; y++) begin
      img[y][7] = c7_in[y]; exp_img[y][7] = c7_exp[y];
      img[y][2] = c2_in[y]; exp_img[y][2] = c2_exp[y];
    end
    start_frame(t0);
    feed_frame(-1, -1, -1, H);
    check_frame("columns", 17'd1);
    for (int y = 0; y < 5; y++) begin
      total++;
      if (wr_val[y][7] !== c7_exp[y]) begin
        bad++; $display("FAIL col7_y%0d: got %0d required %0d", y, wr_val[y][7], c7_exp[y]);
      end
    end
  endtask

  // 300 lossy columns plus a 5-cycle framebuffer stall at x=100.
  task automatic test_lossy_stall();
    int t0;
    clear_log();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < 300; x++) begin
        img[y][x] = (y == 1) ? 3'd0 : 3'd4;
        exp_img[y][x] = (y == 0) ? 3'd4 : 3'd0;
      end
    mon_stall_x = 100; mon_stall_y = 0;
    start_frame(t0);
    feed_frame(100, 0, -1, H);
    check_frame("lossy300", 17'd300);
    total++;
    if (after_x != 101 || after_y != 0) begin
      bad++; $display("FAIL after_stall: next write (%0d,%0d) required (101,0)", after_x, after_y);
    end
  endtask

  // Reset in the middle of a frame, then a clean frame with frame_start
  // pulses during STREAM and in the frame_done cycle.
  task automatic test_reset_and_ignore();
    int t0, k;
    logic ok, quiet;
    clear_log();
    for (int x = 0; x < W; x++) img[0][x] = 3'd1;
    start_frame(t0);
    feed_frame(-1, -1, -1, 4);
    total++;
    if (lossy_count !== 17'd959) begin
      bad++; $display("FAIL lossy_before_reset: got %0d required 959", lossy_count);
    end
    pix_valid = 1'b1;
    Reset = 1'b1;
    @(negedge Clk);
    total++;
    if (pix_ready !== 1'b0 || fb_we !== 1'b0 || fb_coords !== 17'd0 || fb_data !== 3'd0 ||
        busy !== 1'b0 || frame_done !== 1'b0 || lossy_count !== 17'd0) begin
      bad++;
      $display("FAIL midframe_reset: rdy=%b we=%b xy=%h data=%0d busy=%b done=%b lossy=%0d required all 0",
               pix_ready, fb_we, fb_coords, fb_data, busy, frame_done, lossy_count);
    end
    @(posedge Clk); #1;
    Reset = 1'b0; pix_valid = 1'b0;
    repeat (2) begin @(posedge Clk); #1; end

    clear_log();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        img[y][x] = 3'(x % 7);
        exp_img[y][x] = (y == 0) ? 3'(x % 7) : 3'd0;
      end
    start_frame(t0);
    feed_frame(-1, -1, 1000, H);
    ok = 1'b0;
    for (k = 0; k < 50 && !ok; k++) begin
      @(negedge Clk);
      if (frame_done === 1'b1) begin frame_start = 1'b1; ok = 1'b1; end
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL done_wait: frame_done=%b required 1 within 50 cycles", frame_done);
    end
    @(posedge Clk); #1;
    frame_start = 1'b0;
    quiet = 1'b1;
    for (k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (busy !== 1'b0 || fb_we !== 1'b0) quiet = 1'b0;
    end
    @(posedge Clk); #1;
    total++;
    if (!quiet) begin
      bad++; $display("FAIL start_at_done: busy=%b we=%b required 0 0 (no second frame)", busy, fb_we);
    end
    check_frame("after_reset", 17'd0);
  endtask

  initial begin
    test_reset();
    test_solid();
    test_columns();
    test_lossy_stall();
    test_reset_and_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
